// File: rtl/pipe_pkg.sv
// Types and constants shared by the pipeline skid stage and its testbench.
package pipe_pkg;

    localparam int PIPE_CNT_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    function automatic logic [PIPE_CNT_W-1:0] state_count(input stage_state_t s);
        case (s)
            BUSY:    state_count = PIPE_CNT_W'(1);
            FULL:    state_count = PIPE_CNT_W'(2);
            default: state_count = '0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous clear; clear has priority.
module pipe_data_reg #(
    parameter int DATA_W = 147
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// freeze (stall) and flush. in_ready and out_data are direct flop outputs.
//
// state | meaning
// EMPTY | nothing held, count 0
// BUSY  | main register valid, count 1
// FULL  | main and skid valid, count 2, in_ready low
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 147,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_CNT_W-1:0] count
);

    stage_state_t          state_q, state_d;
    logic                  in_ready_q;
    logic [PIPE_CNT_W-1:0] count_q;

    logic                  in_xfer, out_xfer;
    logic                  main_load, main_from_skid, skid_load, data_clr;
    logic [DATA_W-1:0]     main_d, skid_q;

    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid & in_ready_q & ~flush;
    assign out_xfer  = out_valid & out_ready & ~freeze;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d   = BUSY;
                    main_load = 1'b1;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end else if (out_xfer) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d        = BUSY;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // An output transfer in the flush cycle has already completed downstream.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    assign main_d   = main_from_skid ? skid_q : in_data;
    assign data_clr = rst | (flush & (CLEAR_ON_FLUSH != 0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
            count_q    <= state_count(state_d);
        end
    end

    pipe_data_reg #(.DATA_W(DATA_W)) u_main_reg (
        .clk    (clk),
        .clr_i  (data_clr),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (out_data)
    );

    pipe_data_reg #(.DATA_W(DATA_W)) u_skid_reg (
        .clk    (clk),
        .clr_i  (data_clr),
        .load_i (skid_load),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

    assign in_ready = in_ready_q;
    assign count    = count_q;

endmodule
